stack_unit: RTL and testbench
=============================

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits.
REQ-002 Parameter DEPTH, default 16: maximum number of stored entries; SHALL be a power of two and at least 4.
REQ-003 CLK  input  1  single clock; all state updates occur on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 stackAction  input  3  action code; sampled on each rising CLK edge.
REQ-006 dIn  input  WIDTH  write data for push and replace actions.
REQ-007 top  output  WIDTH  entry at the top of the stack.
REQ-008 next  output  WIDTH  entry directly below the top (ALU second operand).
REQ-009 popData  output  WIDTH  registered value removed by the most recent successful pop.
REQ-010 count  output  log2(DEPTH)+1  number of valid entries.
REQ-011 full  output  1  high when count==DEPTH.
REQ-012 empty  output  1  high when count==0.
REQ-013 error  output  1  sticky flag for an illegal or rejected action.

Function
REQ-014 Action codes and the minimum count required for each:
- 000 nop: no change.
- 001 pop: popData<=top; count-1; requires count>=1.
- 010 drop: count-1; popData unchanged; requires count>=1.
- 011 replace: removes the top two entries and pushes dIn, so the new top is dIn and count-1; requires count>=2.
- 100 push: new top is dIn; count+1; requires count<DEPTH.
- 101 dup: new top is a copy of the old top; count+1; requires 1<=count<DEPTH.
- 110 reserved: always rejected.
- 111 swap: exchanges top and next; count unchanged; requires count>=2.
REQ-015 Every action takes exactly one cycle. Results SHALL be visible on top, next, count and popData immediately after the sampling edge.
REQ-016 top SHALL be combinational from the storage array: entry[count-1] when count>=1, otherwise 0.
REQ-017 next SHALL be combinational from the storage array: entry[count-2] when count>=2, otherwise 0.
REQ-018 full and empty SHALL be combinational decodes of count.
REQ-019 A rejected action is one that fails its count precondition, or is code 110. On a rejected action:
- count, the storage array and popData SHALL NOT change;
- error SHALL be set to 1 on that edge;
- error SHALL stay 1 until reset.
REQ-020 Overflow boundary: push or dup at count==DEPTH is rejected, and the existing entry[DEPTH-1] is preserved.
REQ-021 Underflow boundary: pop or drop at count==0, and replace or swap at count<=1, are rejected.
REQ-022 count SHALL never wrap; it stays within 0..DEPTH at all times.
REQ-023 replace SHALL write dIn to entry[count-2] in the same edge that count decrements.
REQ-024 The unit SHALL be usable for the data, procedure and return stacks without modification; per-instance action codes are identical.

Reset
REQ-025 While Reset is low: count=0, popData=0, error=0. As a result top=0, next=0, empty=1, full=0.
REQ-026 Storage array contents are not reset; they SHALL be unobservable because of REQ-016 and REQ-017.
REQ-027 Reset asserted during any action SHALL immediately force the REQ-025 values. The action in progress SHALL have no effect.
REQ-028 The first action is sampled on the first rising CLK edge after Reset is released high.

Verification
REQ-029 Push sequence. Reset, then push 0x0011, push 0x0022 -> top=0x0022, next=0x0011, count=2, error=0.
REQ-030 Replace and pop. From REQ-029, replace with dIn=0x0033 -> top=0x0033, count=1, next=0. Then pop -> popData=0x0033, count=0, empty=1.
REQ-031 Swap and dup. Push 0x000A, push 0x000B, swap -> top=0x000A, next=0x000B. Then dup -> top=0x000A, next=0x000A, count=3.
REQ-032 Overflow. Fill to DEPTH with values 1..16 -> full=1. Then push 0xFFFF -> top=0x0010, count=16, error=1.
REQ-033 Underflow and reserved code. From reset, drop -> count=0, error=1. Reset again, then apply code 110 -> error=1, count=0.
REQ-034 Reset mid-operation. With count=5, assert Reset low asynchronously between edges -> count=0, top=0, popData=0, error=0 without waiting for a CLK edge.

Source files
------------

// File: rtl/stack_unit_if.sv
// Bus between a stack controller and stack_unit: action/data in, stack view out.
// The same interface serves data, procedure and return stack instances.
interface stack_unit_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  logic [2:0]              stackAction;
  logic [WIDTH-1:0]        dIn;
  logic [WIDTH-1:0]        top;
  logic [WIDTH-1:0]        next;
  logic [WIDTH-1:0]        popData;
  logic [$clog2(DEPTH):0]  count;
  logic                    full;
  logic                    empty;
  logic                    error;

  modport master (
    output stackAction, dIn,
    input  top, next, popData, count, full, empty, error
  );

  modport slave (
    input  stackAction, dIn,
    output top, next, popData, count, full, empty, error
  );
endinterface

// File: rtl/stack_unit.sv
// Single-cycle hardware stack with push/pop/drop/replace/dup/swap actions.
// Top and next are read combinationally; illegal actions set a sticky error.
module stack_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  stack_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    ACT_NOP     = 3'b000,
    ACT_POP     = 3'b001,
    ACT_DROP    = 3'b010,
    ACT_REPLACE = 3'b011,
    ACT_PUSH    = 3'b100,
    ACT_DUP     = 3'b101,
    ACT_RSVD    = 3'b110,
    ACT_SWAP    = 3'b111
  } action_t;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] pop_data_reg, pop_data_next;
  logic             error_reg, error_next;

  logic [AW-1:0]    free_idx, top_idx, next_idx;
  logic [WIDTH-1:0] top_val, next_val;
  logic             has_one, has_two, not_full, accept;

  logic             wr_a_en, wr_b_en;
  logic [AW-1:0]    wr_a_idx, wr_b_idx;
  logic [WIDTH-1:0] wr_a_data, wr_b_data;

  // Modulo-DEPTH indexing: at count==DEPTH free_idx wraps to 0 but is never written.
  assign free_idx = cnt_reg[AW-1:0];
  assign top_idx  = free_idx - AW'(1);
  assign next_idx = free_idx - AW'(2);

  assign has_one  = (cnt_reg != '0);
  assign has_two  = (cnt_reg >= CW'(2));
  assign not_full = (cnt_reg != CW'(DEPTH));

  assign top_val  = mem[top_idx];
  assign next_val = mem[next_idx];

  always_comb begin
    accept        = 1'b0;
    cnt_next      = cnt_reg;
    pop_data_next = pop_data_reg;
    wr_a_en       = 1'b0;
    wr_a_idx      = free_idx;
    wr_a_data     = bus.dIn;
    wr_b_en       = 1'b0;
    wr_b_idx      = next_idx;
    wr_b_data     = top_val;
    case (bus.stackAction)
      ACT_NOP: accept = 1'b1;
      ACT_POP: if (has_one) begin
        accept        = 1'b1;
        cnt_next      = cnt_reg - CW'(1);
        pop_data_next = top_val;
      end
      ACT_DROP: if (has_one) begin
        accept   = 1'b1;
        cnt_next = cnt_reg - CW'(1);
      end
      ACT_REPLACE: if (has_two) begin
        accept   = 1'b1;
        cnt_next = cnt_reg - CW'(1);
        wr_a_en  = 1'b1;
        wr_a_idx = next_idx;
      end
      ACT_PUSH: if (not_full) begin
        accept   = 1'b1;
        cnt_next = cnt_reg + CW'(1);
        wr_a_en  = 1'b1;
      end
      ACT_DUP: if (has_one && not_full) begin
        accept    = 1'b1;
        cnt_next  = cnt_reg + CW'(1);
        wr_a_en   = 1'b1;
        wr_a_data = top_val;
      end
      ACT_SWAP: if (has_two) begin
        accept    = 1'b1;
        wr_a_en   = 1'b1;
        wr_a_idx  = top_idx;
        wr_a_data = next_val;
        wr_b_en   = 1'b1;
      end
      default: accept = 1'b0;
    endcase
    error_next = error_reg | ~accept;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cnt_reg      <= '0;
      pop_data_reg <= '0;
      error_reg    <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      pop_data_reg <= pop_data_next;
      error_reg    <= error_next;
    end
  end

  // Storage is deliberately not reset; count gating hides stale contents.
  always_ff @(posedge CLK) begin
    if (wr_a_en) mem[wr_a_idx] <= wr_a_data;
    if (wr_b_en) mem[wr_b_idx] <= wr_b_data;
  end

  assign bus.top     = has_one ? top_val  : '0;
  assign bus.next    = has_two ? next_val : '0;
  assign bus.popData = pop_data_reg;
  assign bus.count   = cnt_reg;
  assign bus.full    = (cnt_reg == CW'(DEPTH));
  assign bus.empty   = (cnt_reg == '0);
  assign bus.error   = error_reg;
endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: hand-computed vectors checked with immediate assertions.
module tb_stack_unit;
  localparam int WIDTH = 16;
  localparam int DEPTH = 16;

  localparam logic [2:0] NOP = 3'b000, POP = 3'b001, DROP = 3'b010, REPL = 3'b011,
                         PUSH = 3'b100, DUP = 3'b101, RSVD = 3'b110, SWAP = 3'b111;

  logic CLK = 1'b0;
  logic Reset = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  stack_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic act(input logic [2:0] code, input logic [WIDTH-1:0] din);
    @(negedge CLK);
    bus.stackAction = code;
    bus.dIn = din;
    @(posedge CLK);
    #1;
    bus.stackAction = NOP;
    $display("act=%b din=%h -> top=%h next=%h count=%0d popData=%h err=%b",
             code, din, bus.top, bus.next, bus.count, bus.popData, bus.error);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);
    Reset = 1'b1;
  endtask

  initial begin
    bus.stackAction = NOP;
    bus.dIn = '0;
    #12;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_top", 32'(bus.top), 0);
    chk("rst_next", 32'(bus.next), 0);
    chk("rst_pop", 32'(bus.popData), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_error", 32'(bus.error), 0);
    @(negedge CLK);
    Reset = 1'b1;

    // Push sequence
    act(PUSH, 16'h0011);
    act(PUSH, 16'h0022);
    chk("push_top", 32'(bus.top), 32'h22);
    chk("push_next", 32'(bus.next), 32'h11);
    chk("push_count", 32'(bus.count), 2);
    chk("push_error", 32'(bus.error), 0);

    // Replace and pop
    act(REPL, 16'h0033);
    chk("repl_top", 32'(bus.top), 32'h33);
    chk("repl_count", 32'(bus.count), 1);
    chk("repl_next", 32'(bus.next), 0);
    act(POP, 16'h0000);
    chk("pop_data", 32'(bus.popData), 32'h33);
    chk("pop_count", 32'(bus.count), 0);
    chk("pop_empty", 32'(bus.empty), 1);

    // Swap and dup
    act(PUSH, 16'h000A);
    act(PUSH, 16'h000B);
    act(SWAP, 16'h0000);
    chk("swap_top", 32'(bus.top), 32'hA);
    chk("swap_next", 32'(bus.next), 32'hB);
    act(DUP, 16'h0000);
    chk("dup_top", 32'(bus.top), 32'hA);
    chk("dup_next", 32'(bus.next), 32'hA);
    chk("dup_count", 32'(bus.count), 3);
    act(DROP, 16'h1234);
    act(DROP, 16'h1234);
    chk("drop_top", 32'(bus.top), 32'hB);
    chk("drop_pop_kept", 32'(bus.popData), 32'h33);
    chk("legal_error", 32'(bus.error), 0);

    // Overflow
    do_reset();
    for (int i = 1; i <= DEPTH; i++) act(PUSH, 16'(i));
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_top", 32'(bus.top), 32'h10);
    act(PUSH, 16'hFFFF);
    chk("ovf_top", 32'(bus.top), 32'h10);
    chk("ovf_count", 32'(bus.count), 16);
    chk("ovf_error", 32'(bus.error), 1);
    act(DUP, 16'h0000);
    chk("ovf_dup_count", 32'(bus.count), 16);
    act(POP, 16'h0000);
    chk("ovf_pop_data", 32'(bus.popData), 32'h10);
    chk("ovf_pop_top", 32'(bus.top), 32'hF);
    chk("ovf_error_sticky", 32'(bus.error), 1);

    // Underflow and reserved code
    do_reset();
    chk("rst2_error", 32'(bus.error), 0);
    act(DROP, 16'h0000);
    chk("udf_count", 32'(bus.count), 0);
    chk("udf_error", 32'(bus.error), 1);
    do_reset();
    act(RSVD, 16'h0000);
    chk("rsvd_error", 32'(bus.error), 1);
    chk("rsvd_count", 32'(bus.count), 0);
    do_reset();
    act(PUSH, 16'h0005);
    act(SWAP, 16'h0000);
    chk("swap1_count", 32'(bus.count), 1);
    chk("swap1_top", 32'(bus.top), 32'h5);
    chk("swap1_error", 32'(bus.error), 1);
    act(REPL, 16'h0077);
    chk("repl1_top", 32'(bus.top), 32'h5);
    chk("repl1_count", 32'(bus.count), 1);
    act(POP, 16'h0000);
    act(POP, 16'h0000);
    chk("udf_pop_data", 32'(bus.popData), 32'h5);
    chk("udf_pop_count", 32'(bus.count), 0);

    // Asynchronous reset mid-operation
    do_reset();
    for (int i = 1; i <= 6; i++) act(PUSH, 16'(16'h0100 + i));
    act(POP, 16'h0000);
    act(RSVD, 16'h0000);
    chk("pre_count", 32'(bus.count), 5);
    chk("pre_pop", 32'(bus.popData), 32'h0106);
    @(posedge CLK);
    #2;
    bus.stackAction = PUSH;
    bus.dIn = 16'hBEEF;
    Reset = 1'b0;
    #1;
    chk("async_count", 32'(bus.count), 0);
    chk("async_top", 32'(bus.top), 0);
    chk("async_pop", 32'(bus.popData), 0);
    chk("async_error", 32'(bus.error), 0);
    chk("async_empty", 32'(bus.empty), 1);
    @(posedge CLK);
    #1;
    chk("held_count", 32'(bus.count), 0);
    @(negedge CLK);
    bus.stackAction = NOP;
    Reset = 1'b1;
    act(PUSH, 16'h4242);
    chk("post_top", 32'(bus.top), 32'h4242);
    chk("post_count", 32'(bus.count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
